// File: rtl/if_pkg.sv
// -----------------------------------------------------------------------------
// if_pkg
// Types and constants shared by the instruction fetch front end.
//   NOP_INSTR      : instruction presented when no fetched entry is available
//   fetch_state_t  : request FSM states (IDLE, WAIT, DISCARD)
//   fetch_entry_t  : one prefetch FIFO entry {pc_plus4, instr}
// -----------------------------------------------------------------------------
package if_pkg;

   localparam logic [31:0] NOP_INSTR = 32'hE000_0000;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT    = 2'd1,
      DISCARD = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] pc_plus4;
      logic [31:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/instr_prefetch_fifo.sv
// -----------------------------------------------------------------------------
// instr_prefetch_fifo
// DEPTH-entry synchronous FIFO of fetched instructions. Flush wins over push
// and pop; a pop on an empty FIFO or a push on a full one (without a pop in
// the same cycle) is ignored.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   flush       : drop all entries (count -> 0)
//   push        : write push_data at the tail
//   push_data   : entry to write
//   pop         : retire the head entry
//   count       : number of valid entries (0..DEPTH)
//   head        : entry at the head (undefined contents when count == 0)
// -----------------------------------------------------------------------------
module instr_prefetch_fifo
   import if_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   push,
   input  fetch_entry_t           push_data,
   input  logic                   pop,
   output logic [$clog2(DEPTH):0] count,
   output fetch_entry_t           head
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   fetch_entry_t  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign do_pop  = pop && (count != '0);
   assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   // NOTE: the storage array has no reset; count alone says which entries are
   // meaningful, so clearing the data would only cost reset fan-out.
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= push_data;
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// Pipeline front end: owns the fetch PC, fetches over a single-outstanding
// req/ack memory handshake, buffers instructions in instr_prefetch_fifo and
// presents the head entry to the IF/ID register.
// Ports:
//   clk, rst         : clock, asynchronous active-high reset
//   freeze           : IF/ID stall, head entry is held
//   branch_taken     : redirect pulse from EXE, flushes the FIFO
//   branch_addr      : redirect target (word aligned)
//   mem_req/mem_addr : fetch request and address (stable while mem_req=1)
//   mem_ack/mem_rdata: one-cycle ack with the fetched instruction
//   pc_out           : head entry address + 4 (0 when empty)
//   instr_out        : head entry instruction (NOP_INSTR when empty)
//   instr_valid      : FIFO non-empty
// Optional feature (macro IF_FETCH_PERF_EN): adds saturating counters
//   perf_fetch_cnt (accepted acks) and perf_discard_cnt (dropped acks).
// -----------------------------------------------------------------------------
module instr_fetch_unit
   import if_pkg::*;
#(
   parameter int          DEPTH     = 2,
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = if_pkg::NOP_INSTR
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        freeze,
   input  logic        branch_taken,
   input  logic [31:0] branch_addr,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic [31:0] pc_out,
   output logic [31:0] instr_out,
   output logic        instr_valid
`ifdef IF_FETCH_PERF_EN
   ,
   output logic [31:0] perf_fetch_cnt,
   output logic [15:0] perf_discard_cnt
`endif
);

   localparam int CW = $clog2(DEPTH) + 1;

   fetch_state_t  state;
   fetch_state_t  state_next;
   logic [31:0]   fetch_pc;
   logic [CW-1:0] count;
   logic [CW-1:0] count_after;
   fetch_entry_t  head;
   fetch_entry_t  push_entry;
   logic          fifo_push;
   logic          fifo_pop;
   logic          fifo_flush;
   logic          ack_drop;
   logic          has_space;
   logic          space_after;

   instr_prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (fifo_flush),
      .push      (fifo_push),
      .push_data (push_entry),
      .pop       (fifo_pop),
      .count     (count),
      .head      (head)
   );

   assign instr_valid = (count != '0);
   assign push_entry  = '{pc_plus4: fetch_pc + 32'd4, instr: mem_rdata};
   assign has_space   = (count < CW'(DEPTH));
   // Occupancy after this edge; counting the pop lets a 1-cycle memory keep
   // one request in flight every cycle even with DEPTH = 2.
   assign count_after = count + CW'(fifo_push) - CW'(fifo_pop);
   assign space_after = (count_after < CW'(DEPTH));

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of process evaluation order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // NOTE: state_next is given its default before the case so every path
   // assigns it and no latch is inferred.
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE: begin
            // A branch here retargets fetch_pc first; the request goes out next cycle.
            if (!branch_taken && has_space) state_next = WAIT;
         end
         WAIT: begin
            if (branch_taken)  state_next = mem_ack ? IDLE : DISCARD;
            else if (mem_ack)  state_next = space_after ? WAIT : IDLE;
         end
         DISCARD: begin
            // A branch only retargets fetch_pc; the stale ack still ends DISCARD.
            if (mem_ack) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      mem_req    = (state != IDLE);
      fifo_flush = branch_taken;
      fifo_push  = (state == WAIT) && mem_ack && !branch_taken;
      fifo_pop   = instr_valid && !freeze && !branch_taken;
      ack_drop   = mem_ack && ((state == DISCARD) || ((state == WAIT) && branch_taken));
      instr_out  = instr_valid ? head.instr    : NOP_INSTR;
      pc_out     = instr_valid ? head.pc_plus4 : 32'h0;
   end

   // fetch_pc always holds the address of the next (or in-flight) fetch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc <= RESET_PC;
         mem_addr <= RESET_PC;
      end else begin
         if (branch_taken)   fetch_pc <= branch_addr;
         else if (fifo_push) fetch_pc <= fetch_pc + 32'd4;

         if ((state == IDLE) && (state_next == WAIT))   mem_addr <= fetch_pc;
         else if (fifo_push && (state_next == WAIT))    mem_addr <= fetch_pc + 32'd4;
      end
   end

`ifdef IF_FETCH_PERF_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_fetch_cnt   <= '0;
         perf_discard_cnt <= '0;
      end else begin
         if (fifo_push && (perf_fetch_cnt != '1))  perf_fetch_cnt   <= perf_fetch_cnt + 32'd1;
         if (ack_drop && (perf_discard_cnt != '1)) perf_discard_cnt <= perf_discard_cnt + 16'd1;
      end
   end
`else
   logic unused_ack_drop;
   assign unused_ack_drop = ack_drop;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
// Expected behaviour: after reset or a branch to T, the consumed entries are
// exactly T, T+4, T+8 ... (modulo 2^32) with pc_out = addr+4 and
// instr_out = addr | 0xE1A00000. A queue holds that stream; a monitor pops it
// on every consume. Directed phases cover the timing rules.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP      = 32'hE000_0000;
   localparam logic [31:0] PATTERN  = 32'hE1A0_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        freeze;
   logic        branch_taken;
   logic [31:0] branch_addr;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic [31:0] pc_out;
   logic [31:0] instr_out;
   logic        instr_valid;
`ifdef IF_FETCH_PERF_EN
   logic [31:0] perf_fetch_cnt;
   logic [15:0] perf_discard_cnt;
`endif

   always #5 clk = ~clk;

   instr_fetch_unit #(.DEPTH(2), .RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
      .clk          (clk),
      .rst          (rst),
      .freeze       (freeze),
      .branch_taken (branch_taken),
      .branch_addr  (branch_addr),
      .mem_req      (mem_req),
      .mem_addr     (mem_addr),
      .mem_ack      (mem_ack),
      .mem_rdata    (mem_rdata),
      .pc_out       (pc_out),
      .instr_out    (instr_out),
      .instr_valid  (instr_valid)
`ifdef IF_FETCH_PERF_EN
      ,
      .perf_fetch_cnt   (perf_fetch_cnt),
      .perf_discard_cnt (perf_discard_cnt)
`endif
   );

   int          total = 0;
   int          bad   = 0;
   int          pops  = 0;
   logic [63:0] exp_q [$];
   bit          rand_mode = 1'b0;
   bit          ack_hold  = 1'b0;
   bit          pending   = 1'b0;
   int          lat       = 0;
   int          ack_lat_max = 0;
   logic [31:0] pend_addr = '0;
   int          p0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Program-order stream starting at the given address.
   function automatic void fill(input logic [31:0] start);
      logic [31:0] a = start;
      exp_q.delete();
      repeat (512) begin
         exp_q.push_back({a + 32'd4, a | PATTERN});
         a = a + 32'd4;
      end
   endfunction

   // Memory responder: acks the current request after 0..ack_lat_max cycles.
   task automatic drive_mem();
      mem_ack = 1'b0;
      if (ack_hold || !mem_req) return;
      if (!pending) begin
         pending   = 1'b1;
         pend_addr = mem_addr;
         lat       = (ack_lat_max == 0) ? 0 : int'($urandom_range(0, ack_lat_max));
      end else begin
         check("addr_stable", mem_addr, pend_addr);
      end
      if (lat == 0) begin
         mem_ack   = 1'b1;
         mem_rdata = mem_addr | PATTERN;
         pending   = 1'b0;
      end else begin
         lat--;
      end
   endtask

   task automatic step();
      @(negedge clk);
      branch_taken = 1'b0;
      drive_mem();
      if (rand_mode) begin
         freeze = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 15) == 0) begin
            if ($urandom_range(0, 7) == 0) branch_addr = 32'hFFFF_FFF0 + (32'($urandom_range(0, 3)) << 2);
            else                           branch_addr = 32'($urandom_range(0, 255)) << 2;
            branch_taken = 1'b1;
            fill(branch_addr);
         end
      end
   endtask

   task automatic wait_req();
      int n = 0;
      while (!mem_req && n < 50) begin
         step();
         n++;
      end
      check("req_within_bound", mem_req, 1'b1);
   endtask

   task automatic reset_vals();
      check("rst_mem_req", mem_req, 1'b0);
      check("rst_mem_addr", mem_addr, RESET_PC);
      check("rst_head", {instr_valid, pc_out, instr_out}, {1'b0, 32'h0, NOP});
`ifdef IF_FETCH_PERF_EN
      check("rst_perf_fetch", perf_fetch_cnt, 32'h0);
      check("rst_perf_discard", perf_discard_cnt, 16'h0);
`endif
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      mem_ack = 1'b0;
      branch_taken = 1'b0;
      @(negedge clk);
      reset_vals();
      rst = 1'b0;
      fill(RESET_PC);
      pending = 1'b0;
   endtask

   // Monitor: checks the head whenever it is consumed, and the empty value.
   initial begin
      logic [63:0] exp;
      forever begin
         @(negedge clk);
         #1;
         if (!rst) begin
            if (!instr_valid) begin
               check("empty_head", {pc_out, instr_out}, {32'h0, NOP});
            end else if (!freeze && !branch_taken) begin
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL stream_underrun: got pc_out %h with no expected entry left", pc_out);
               end else begin
                  exp = exp_q.pop_front();
                  check("pop_entry", {pc_out, instr_out}, exp);
               end
               pops++;
            end
         end
      end
   end

   initial begin
      rst = 1'b1;
      freeze = 1'b0;
      branch_taken = 1'b0;
      branch_addr = '0;
      mem_ack = 1'b0;
      mem_rdata = '0;

      // Reset values, first request, 1 instruction per cycle.
      repeat (2) @(negedge clk);
      reset_vals();
      rst = 1'b0;
      fill(RESET_PC);
      check("req_low_before_edge", mem_req, 1'b0);
      step();
      check("first_req", {mem_req, mem_addr}, {1'b1, RESET_PC});
      step();
      check("first_valid", {instr_valid, pc_out}, {1'b1, RESET_PC + 32'd4});
      p0 = pops;
      repeat (20) step();
      check("throughput_20", 32'(pops - p0), 32'd20);

      // Freeze fills the FIFO, requests stop, release drains then refetches at 8.
      freeze = 1'b1;
      do_reset();
      repeat (6) step();
      check("frozen_full", {mem_req, instr_valid}, {1'b0, 1'b1});
      freeze = 1'b0;
      p0 = pops;
      step();
      step();
      #2;
      check("two_pops", 32'(pops - p0), 32'd2);
      check("resume_addr", {mem_req, mem_addr}, {1'b1, 32'd8});

      // Branch while a request is outstanding: late ack is dropped.
      ack_hold = 1'b1;
      step();
      check("pre_branch_req", mem_req, 1'b1);
      branch_taken = 1'b1;
      branch_addr = 32'h100;
      fill(32'h100);
      step();
      check("discard_hold", {instr_valid, mem_req, mem_addr}, {1'b0, 1'b1, 32'd12});
      step();
      step();
      mem_ack = 1'b1;
      mem_rdata = mem_addr | PATTERN;
      step();
      check("after_drop", {mem_req, instr_valid}, {1'b0, 1'b0});
      step();
      check("branch_target_req", {mem_req, mem_addr}, {1'b1, 32'h100});
      ack_hold = 1'b0;
      pending = 1'b0;
      repeat (4) step();

      // Branch coinciding with ack and pop.
      check("pre_branch_ack_pop", {mem_req, mem_ack, instr_valid}, 3'b111);
      branch_taken = 1'b1;
      branch_addr = 32'h200;
      fill(32'h200);
      step();
      check("branch_ack_flush", {instr_valid, mem_req}, {1'b0, 1'b0});
      step();
      check("branch_ack_req", {mem_req, mem_addr}, {1'b1, 32'h200});

      // Address wrap at the top of memory.
      branch_taken = 1'b1;
      branch_addr = 32'hFFFF_FFF8;
      fill(32'hFFFF_FFF8);
      step();
      step();
      check("wrap_addr0", {mem_req, mem_addr}, {1'b1, 32'hFFFF_FFF8});
      step();
      check("wrap_addr1", {mem_req, mem_addr}, {1'b1, 32'hFFFF_FFFC});
      step();
      check("wrap_addr2", {mem_req, mem_addr}, {1'b1, 32'h0});
      repeat (4) step();

      // Randomized freeze, branches and memory latency.
      ack_lat_max = 3;
      rand_mode = 1'b1;
      repeat (1500) step();
      rand_mode = 1'b0;
      freeze = 1'b0;
      repeat (10) step();

      // Reset in the middle of a request; the late ack must be ignored.
      ack_hold = 1'b1;
      wait_req();
      rst = 1'b1;
      #1;
      reset_vals();
      @(negedge clk);
      mem_ack = 1'b1;
      mem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      rst = 1'b0;
      fill(RESET_PC);
      pending = 1'b0;
      ack_hold = 1'b0;
      ack_lat_max = 0;
      check("post_rst_idle", mem_req, 1'b0);
      step();
      check("restart_req", {mem_req, mem_addr}, {1'b1, RESET_PC});
      p0 = pops;
      repeat (10) step();
      check("restart_pops", 32'(pops - p0), 32'd9);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Front end of the 5-stage ARM-style pipeline. It owns the program counter, fetches instructions from instruction memory over a req/ack handshake, and buffers them in a small prefetch FIFO. It presents {PC+4, instruction, valid} to the IF/ID pipeline register, honouring that register's freeze and the branch redirect from EXE.

## Interface

Parameters:
- DEPTH, 2: prefetch FIFO entries, power of two, at least 2.
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- NOP_INSTR, 32'hE000_0000: instruction driven when no valid entry is available.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- freeze  in  1  downstream stall; head entry is not consumed.
- branch_taken  in  1  redirect pulse from EXE.
- branch_addr  in  32  redirect target; word-aligned.
- mem_req  out  1  fetch request.
- mem_addr  out  32  fetch address; stable while mem_req=1.
- mem_ack  in  1  one-cycle pulse; mem_rdata valid in the same cycle.
- mem_rdata  in  32  fetched instruction.
- pc_out  out  32  head entry fetch address + 4.
- instr_out  out  32  head entry instruction.
- instr_valid  out  1  FIFO non-empty.

## Operation

- fetch_pc register is reset to RESET_PC. It advances by 4, wrapping modulo 2^32, on each accepted (non-discarded) ack.
- At most one request is outstanding at a time.
- The FSM has three states:
  - IDLE: if count < DEPTH, assert mem_req with mem_addr = fetch_pc, then go to WAIT.
  - WAIT: hold mem_req and mem_addr. On mem_ack, push {fetch_pc+4, mem_rdata} and advance fetch_pc. If the FIFO would still have space after the push, immediately issue the next request (stay in WAIT with the new address), otherwise go to IDLE.
  - DISCARD: hold mem_req and the old address until mem_ack, drop the data, then go to IDLE.
- Pop happens when instr_valid=1 and freeze=0.
- When the FIFO is empty: instr_valid=0, instr_out=NOP_INSTR, pc_out=0.
- Branch (branch_taken=1) behaviour:
  - Flush the FIFO (count←0) and set fetch_pc←branch_addr.
  - If in WAIT without mem_ack this cycle, go to DISCARD.
  - If in WAIT with mem_ack this cycle, drop that data and go to IDLE.
- Priority, highest first: rst > branch_taken > push/pop. A branch in the same cycle as a pop suppresses the pop's effect; freeze is irrelevant during a flush.
- Push and pop in the same cycle leave count unchanged. A push never overflows because a request is issued only when count < DEPTH.
- A branch while in DISCARD updates fetch_pc only; the FSM remains in DISCARD.

## Timing

- Reset values: mem_req=0, mem_addr=RESET_PC, pc_out=0, instr_out=NOP_INSTR, instr_valid=0, FSM=IDLE, count=0.
- mem_req first rises in the first clock edge after rst deasserts.
- Ack latency to output: data acked at edge N appears as the FIFO head after edge N if the FIFO was empty; instr_valid=1 from that cycle on.
- Branch latency: FIFO is empty after the branch edge. The request to branch_addr is issued the cycle after the branch edge, or the cycle after the discarded ack if one was outstanding.
- Sustained throughput with a 1-cycle-ack memory and freeze=0 is 1 instruction per cycle.
- Outputs are registered or driven from the FIFO head only. There is no combinational path from freeze to mem_req.

## Configuration

- IF_FETCH_PERF_EN defined: adds two output ports.
  - perf_fetch_cnt [31:0]: counts accepted acks.
  - perf_discard_cnt [15:0]: counts dropped acks.
  - Both counters saturate, reset to 0 and are cleared only by rst.
- IF_FETCH_PERF_EN undefined: the ports and counters do not exist; all other behaviour is identical.

## Structure

- Shared package if_pkg contains NOP_INSTR, a fetch_state_t enum (IDLE, WAIT, DISCARD) and a fetch_entry_t struct {pc_plus4[31:0], instr[31:0]}.
- Sub-module instr_prefetch_fifo holds the DEPTH-entry synchronous FIFO with push, pop, flush, count and head outputs. The flush has priority over push and pop.

## Test plan

- Reset, then mem_ack one cycle after each req with rdata=addr|0xE1A00000, freeze=0 → instr_valid from cycle 2; pc_out sequence 4, 8, 12…; one instruction per cycle.
- Hold freeze=1 for 6 cycles → FIFO reaches 2 entries and mem_req drops. On release: two pops in consecutive cycles, then fetching resumes at address 8 with no entry lost or duplicated.
- branch_taken with branch_addr=0x100 while a request is outstanding and ack arrives 3 cycles later → that ack's data is dropped. The next mem_addr is 0x100, the first pc_out after the branch is 0x104, and instr_valid=0 until then.
- Branch in the same cycle as mem_ack and a pop → FIFO empty, data dropped, next mem_addr = branch_addr.
- Set fetch_pc near 0xFFFF_FFFC via branch → the next fetch address wraps to 0x0 and pc_out for that entry is 0x0.
- Assert rst while in WAIT → all outputs return to their reset values immediately. The late mem_ack after rst is ignored and fetching restarts at RESET_PC. With IF_FETCH_PERF_EN defined, the counters read 0.
